// File: rtl/ram_dp_ctrl.sv
// True dual-port RAM with valid/ready requests, byte-lane writes, registered reads,
// zero-clear walk after reset and out-of-range flagging. Optional macro: RAM_COLLISION_FWD_EN.
module ram_dp_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_VALID,
  output logic                  A_READY,
  input  logic                  A_WE,
  input  logic [WIDTH/8-1:0]    A_BE,
  input  logic [ADDR_W-1:0]     A_ADDRESS,
  input  logic [WIDTH-1:0]      A_WD,
  output logic                  A_RVALID,
  output logic [WIDTH-1:0]      A_RD,
  output logic                  A_ERR,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic                  B_WE,
  input  logic [WIDTH/8-1:0]    B_BE,
  input  logic [ADDR_W-1:0]     B_ADDRESS,
  input  logic [WIDTH-1:0]      B_WD,
  output logic                  B_RVALID,
  output logic [WIDTH-1:0]      B_RD,
  output logic                  B_ERR
);

  localparam int NBYTES = WIDTH / 8;

  // Handshake: a request is taken on a posedge where VALID && READY; READY is a pure
  // function of the FSM (high only in RUN and not under reset), so nothing is queued.
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic                a_rvalid_q, a_err_q, b_rvalid_q, b_err_q;
  logic [WIDTH-1:0]    a_rd_q, b_rd_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < 32'(DEPTH);
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [NBYTES-1:0] be);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NBYTES; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  logic a_acc, b_acc, a_oor, b_oor, a_wr, b_wr, a_rd, b_rd, same_addr;
  logic [WIDTH-1:0] a_old, b_old, a_rword, b_rword, a_wword, b_wword;

  assign A_READY   = (state_q == S_RUN) && !RST;
  assign B_READY   = (state_q == S_RUN) && !RST;
  assign a_acc     = A_VALID && A_READY;
  assign b_acc     = B_VALID && B_READY;
  assign a_oor     = !in_range(A_ADDRESS);
  assign b_oor     = !in_range(B_ADDRESS);
  assign a_wr      = a_acc && A_WE && !a_oor;
  assign b_wr      = b_acc && B_WE && !b_oor;
  assign a_rd      = a_acc && !A_WE;
  assign b_rd      = b_acc && !B_WE;
  assign same_addr = (A_ADDRESS == B_ADDRESS);

  assign a_old   = a_oor ? '0 : mem[A_ADDRESS];
  assign b_old   = b_oor ? '0 : mem[B_ADDRESS];
  assign b_wword = merge(b_old, B_WD, B_BE);
  // A is layered over B's result so that on a shared address A wins its enabled lanes.
  assign a_wword = merge((b_wr && same_addr) ? b_wword : a_old, A_WD, A_BE);

`ifdef RAM_COLLISION_FWD_EN
  assign a_rword = (b_wr && same_addr) ? b_wword : a_old;
  assign b_rword = (a_wr && same_addr) ? a_wword : b_old;
`else
  assign a_rword = a_old;
  assign b_rword = b_old;
`endif

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == S_CLEAR) begin
        mem[clr_q] <= '0;
      end else begin
        if (b_wr) mem[B_ADDRESS] <= b_wword;
        if (a_wr) mem[A_ADDRESS] <= a_wword;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      a_rd_q     <= '0;
      b_rvalid_q <= 1'b0;
      b_err_q    <= 1'b0;
      b_rd_q     <= '0;
    end else begin
      a_rvalid_q <= a_rd;
      a_err_q    <= a_acc && a_oor;
      b_rvalid_q <= b_rd;
      b_err_q    <= b_acc && b_oor;
      if (a_rd) a_rd_q <= a_rword;
      if (b_rd) b_rd_q <= b_rword;
    end
  end

  assign A_RVALID = a_rvalid_q;
  assign A_ERR    = a_err_q;
  assign A_RD     = a_rd_q;
  assign B_RVALID = b_rvalid_q;
  assign B_ERR    = b_err_q;
  assign B_RD     = b_rd_q;

endmodule

// File: doc/ram_dp_ctrl.md
Name: ram_dp_ctrl

Overview:
Parametrised true dual-port synchronous RAM with valid/ready request handshake, byte-lane write enables and registered read data.
- Hardware zero-clear of the whole array after reset.
- Out-of-range access flagging.
- Deterministic same-address collision rules.
- Serves as the shared data/image memory between the vector core (port A) and display/DMA readers (port B).

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 2048, number of words; need not be a power of two
ADDR_W, 11, address width in bits; must satisfy 2**ADDR_W >= DEPTH
NBYTES, WIDTH/8, byte lanes; derived, do not override

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous reset, active-high
A_VALID  in  1  port A request valid
A_READY  out  1  port A can accept a request
A_WE  in  1  1 = write, 0 = read
A_BE  in  NBYTES  byte enables, writes only
A_ADDRESS  in  ADDR_W  word address
A_WD  in  WIDTH  write data
A_RVALID  out  1  read data valid, 1-cycle pulse
A_RD  out  WIDTH  read data
A_ERR  out  1  out-of-range pulse
B_*  same set as port A, same widths and meanings

Behaviour:
- Reset: while RST=1, FSM enters CLEAR and the clear counter is set to 0. READY, RVALID and ERR are 0 on both ports; RD is 0 on both ports.
- FSM states:
  - CLEAR: write 0 to address counter each cycle, counter+1. After writing DEPTH-1, go to RUN next cycle. Takes exactly DEPTH cycles. READY=0 on both ports throughout.
  - RUN: A_READY=B_READY=1 constantly. Terminal; left only by RST.
- RST asserted mid-CLEAR or mid-RUN:
  - Aborts everything and restarts CLEAR from address 0.
  - A read accepted in the cycle RST rises produces no RVALID.
- Accept: a request is accepted in a cycle where VALID&&READY is sampled at posedge. VALID while READY=0 is ignored, not queued.
- Write: for each byte lane i with BE[i]=1, the word at ADDRESS gets WD[8i+7:8i]; other lanes keep their value. BE=0 is a legal no-op that still counts as accepted. No RVALID is produced for writes.
- Read: accepted at edge N. RD is updated and RVALID=1 at edge N+1, so latency is 1 cycle.
  - RVALID is 0 in cycles with no read accepted.
  - RD holds its last value until the next read completes.
  - Back-to-back reads on one port give one result per cycle.
- Out of range (ADDRESS >= DEPTH):
  - Memory is not modified.
  - A read returns RD=0 with RVALID=1.
  - ERR=1 for one cycle, one cycle after acceptance, for reads and writes.
  - ERR=0 otherwise.
- Collisions, same address, same cycle:
  - A write + B write: port A wins on every lane A enables. B's lanes not enabled by A are written by B.
  - Write on one port + read on the other: the reader gets the OLD word (read-before-write). See the optional feature for the alternative.
  - Same-port read+write is impossible (one request per port per cycle).
- No internal reset of array contents other than the CLEAR walk. Array contents are not preserved across RST.

Optional Feature:
RAM_COLLISION_FWD_EN
- Defined: on a write/read same-address collision, the reader's RD is the merged new word. Written lanes come from the writer's WD; unwritten lanes are the old value. If both ports write, the merge follows the A-wins rule.
- Undefined: read-before-write as specified above. No forwarding mux is synthesised.

Test Plan:
- Use WIDTH=32, DEPTH=16 for all scenarios.
- Reset/clear: pulse RST 1 cycle.
  -> READY=0 for exactly 16 cycles, then 1.
  -> Reading addr 0..15 returns 0x00000000 with RVALID one cycle after each request.
- Byte enables: A writes 0xAABBCCDD BE=4'hF to addr 3, then 0x11223344 BE=4'b0101.
  -> A read of addr 3 returns 0xAA22CC44.
- Collision: same cycle, A writes 0xDEADBEEF BE=F to addr 5 while B reads addr 5 holding 0x12345678.
  -> B_RD=0x12345678 with fwd undefined.
  -> B_RD=0xDEADBEEF with RAM_COLLISION_FWD_EN defined.
  -> A subsequent read returns 0xDEADBEEF.
- Dual write: A writes 0x000000FF BE=4'b0001, B writes 0xFFFFFF00 BE=4'b1111, both to addr 7, same cycle.
  -> Read returns 0xFFFFFFFF.
- Out of range: A reads addr 20 and B writes addr 16 with 0x5.
  -> A_RD=0, A_RVALID=1, A_ERR=1 one cycle later; B_ERR=1 one cycle later.
  -> Addr 0 is still 0.
- Reset mid-run: streaming reads on B, assert RST at cycle 3 of the stream.
  -> No RVALID follows RST.
  -> READY=0 for 16 cycles.
  -> All words read back as 0.
